wall_probe_sched: RTL and testbench

//  Time-shares the single combinational maze wall lookup between NUM_REQ movers (player + enemies).

---
 rtl/wall_probe_sched_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/wall_probe_sched.sv | 155 +++++++++++++++
 tb/tb_wall_probe_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wall_probe_sched_pkg.sv
// Shared maze geometry, mover directions and scheduler state encoding
// used by the wall probe scheduler and the movers around it.
package wall_probe_sched_pkg;

  localparam int CELL_SIZE_DEF = 16;
  localparam int MAZE_X0_DEF   = 0;
  localparam int MAZE_Y0_DEF   = 0;
  localparam int MAP_WIDTH     = 40;
  localparam int MAP_HEIGHT    = 30;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_P0,
    S_P1,
    S_P2,
    S_P3,
    S_RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves to just past the served index when advance is pulsed.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] id,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(id) == N - 1) ? '0 : id + IW'(1);
    end
  end

  // Scan from the far end so the requester closest to ptr is written last.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    grant     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant_idx = IW'((int'(ptr) + i) % N);
        found     = 1'b1;
      end
    end
    grant[grant_idx] = found;
  end

endmodule

// File: rtl/wall_probe_sched.sv
// Time-shares the combinational maze wall lookup between movers: arbitrates a
// one-step move, probes the four sprite corners one per cycle, reports the result.
module wall_probe_sched
  import wall_probe_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int STEP      = 1,
  parameter int SPRITE_W  = 8,
  parameter int SPRITE_H  = 8,
  parameter int CELL_SIZE = CELL_SIZE_DEF,
  parameter int MAZE_X0   = MAZE_X0_DEF,
  parameter int MAZE_Y0   = MAZE_Y0_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*10-1:0] req_x,
  input  logic [NUM_REQ*9-1:0] req_y,
  input  logic [NUM_REQ*2-1:0] req_dir,
  output logic [9:0]           probe_x,
  output logic [8:0]           probe_y,
  input  logic                 probe_wall,
  output logic                 busy,
  output logic [NUM_REQ-1:0]   done,
  output logic                 blocked,
  output logic [9:0]           new_x,
  output logic [8:0]           new_y
);

  localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int X_LIM = MAZE_X0 + MAP_WIDTH * CELL_SIZE;
  localparam int Y_LIM = MAZE_Y0 + MAP_HEIGHT * CELL_SIZE;
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] W_OFF  = 11'(SPRITE_W - 1);
  localparam logic signed [10:0] H_OFF  = 11'(SPRITE_H - 1);

  state_t state, state_nxt;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx, id_q;
  logic [9:0]         sel_x, x_q, probe_hold_x;
  logic [8:0]         sel_y, y_q, probe_hold_y;
  dir_t               sel_dir;
  logic signed [10:0] cand_x, cand_y, cx_q, cy_q;
  logic               bounds_fail, blk_q;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .advance  (state == S_RESP),
    .id       (id_q),
    .grant    (gnt),
    .grant_idx(gnt_idx)
  );

  assign sel_x   = req_x[int'(gnt_idx) * 10 +: 10];
  assign sel_y   = req_y[int'(gnt_idx) * 9 +: 9];
  assign sel_dir = dir_t'(req_dir[int'(gnt_idx) * 2 +: 2]);

  // Candidate is signed so a step off the top/left edge reads as negative.
  always_comb begin
    cand_x = signed'({1'b0, sel_x});
    cand_y = signed'({2'b00, sel_y});
    case (sel_dir)
      DIR_UP:    cand_y = cand_y - STEP_S;
      DIR_RIGHT: cand_x = cand_x + STEP_S;
      DIR_DOWN:  cand_y = cand_y + STEP_S;
      DIR_LEFT:  cand_x = cand_x - STEP_S;
      default:   ;
    endcase
    bounds_fail = (int'(cand_x) < MAZE_X0) || (int'(cand_y) < MAZE_Y0) ||
                  (int'(cand_x) + SPRITE_W > X_LIM) ||
                  (int'(cand_y) + SPRITE_H > Y_LIM);
  end

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise a missed branch silently infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_GRANT;
      S_GRANT: state_nxt = !(|gnt) ? S_IDLE : (bounds_fail ? S_RESP : S_P0);
      S_P0:    state_nxt = probe_wall ? S_RESP : S_P1;
      S_P1:    state_nxt = probe_wall ? S_RESP : S_P2;
      S_P2:    state_nxt = probe_wall ? S_RESP : S_P3;
      S_P3:    state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Probe address goes straight to the lookup in the same cycle as the probe.
  always_comb begin
    probe_x = probe_hold_x;
    probe_y = probe_hold_y;
    case (state)
      S_P0: begin probe_x = cx_q[9:0];          probe_y = cy_q[8:0];         end
      S_P1: begin probe_x = 10'(cx_q + W_OFF);  probe_y = cy_q[8:0];         end
      S_P2: begin probe_x = cx_q[9:0];          probe_y = 9'(cy_q + H_OFF);  end
      S_P3: begin probe_x = 10'(cx_q + W_OFF);  probe_y = 9'(cy_q + H_OFF);  end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the small datapath registers are reset too, so a reset mid-probe
      // leaves no stale result or probe address behind.
      state        <= S_IDLE;
      id_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      blk_q        <= 1'b0;
      probe_hold_x <= '0;
      probe_hold_y <= '0;
      done         <= '0;
      blocked      <= 1'b0;
      new_x        <= '0;
      new_y        <= '0;
    end else begin
      state        <= state_nxt;
      probe_hold_x <= probe_x;
      probe_hold_y <= probe_y;
      done         <= '0;
      case (state)
        S_GRANT: begin
          id_q  <= gnt_idx;
          x_q   <= sel_x;
          y_q   <= sel_y;
          cx_q  <= cand_x;
          cy_q  <= cand_y;
          blk_q <= bounds_fail;
        end
        S_P0, S_P1, S_P2, S_P3: begin
          if (probe_wall) blk_q <= 1'b1;
        end
        S_RESP: begin
          done[id_q] <= 1'b1;
          blocked    <= blk_q;
          new_x      <= blk_q ? x_q : cx_q[9:0];
          new_y      <= blk_q ? y_q : cy_q[8:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wall_probe_sched.sv
// Self-checking bench for wall_probe_sched: directed cases plus randomized
// batches against a corner-probing reference model and a tile wall map.
module tb_wall_probe_sched;
  import wall_probe_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [39:0] req_x = '0;
  logic [35:0] req_y = '0;
  logic [7:0]  req_dir = '0;
  logic [9:0]  probe_x;
  logic [8:0]  probe_y;
  logic        probe_wall;
  logic        busy;
  logic [3:0]  done;
  logic        blocked;
  logic [9:0]  new_x;
  logic [8:0]  new_y;

  logic wall_map [64][32];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_ptr = 0;
  int exp_px = 0;
  int exp_py = 0;
  int mx[4], my[4], md[4];

  wall_probe_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_dir   (req_dir),
    .probe_x   (probe_x),
    .probe_y   (probe_y),
    .probe_wall(probe_wall),
    .busy      (busy),
    .done      (done),
    .blocked   (blocked),
    .new_x     (new_x),
    .new_y     (new_y)
  );

  assign probe_wall = wall_map[probe_x[9:4]][probe_y[8:4]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2ms;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_map();
    for (int tx = 0; tx < 64; tx++)
      for (int ty = 0; ty < 32; ty++) wall_map[tx][ty] = 1'b0;
  endtask

  task automatic random_map();
    for (int tx = 0; tx < 64; tx++)
      for (int ty = 0; ty < 32; ty++) wall_map[tx][ty] = ($urandom_range(0, 9) == 0);
  endtask

  task automatic set_mover(input int i, input int x, input int y, input int d);
    mx[i] = x; my[i] = y; md[i] = d;
    req_x[i*10 +: 10] = 10'(x);
    req_y[i*9 +: 9]   = 9'(y);
    req_dir[i*2 +: 2] = 2'(d);
  endtask

  function automatic int pick(input logic [3:0] pend, input int ptr);
    for (int k = 0; k < 4; k++)
      if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // Reference: step, bounds-check against the 640x480 maze, then probe the
  // corners in TL, TR, BL, BR order, stopping at the first wall tile.
  function automatic void model(input int x, input int y, input int d,
                                output int blk, output int nx, output int ny,
                                output int lat, output int lx, output int ly);
    int cx, cy;
    int kx[4], ky[4];
    cx = x; cy = y;
    if (d == 0) cy = y - 1;
    if (d == 1) cx = x + 1;
    if (d == 2) cy = y + 1;
    if (d == 3) cx = x - 1;
    blk = 1; nx = x; ny = y; lat = 2; lx = 0; ly = 0;
    if (cx < 0 || cy < 0 || cx + 8 > 640 || cy + 8 > 480) return;
    kx = '{cx, cx + 7, cx, cx + 7};
    ky = '{cy, cy, cy + 7, cy + 7};
    for (int k = 0; k < 4; k++) begin
      lx = kx[k]; ly = ky[k]; lat = 3 + k;
      if (wall_map[kx[k] / 16][ky[k] / 16]) return;
    end
    blk = 0; nx = cx; ny = cy; lat = 6;
  endfunction

  // Raises the movers in mask and serves every pending request to completion.
  task automatic serve(input logic [3:0] mask, input bit disturb);
    logic [3:0] pending;
    int g, n, id, blk, nx, ny, lat, lx, ly;
    req = req | mask;
    pending = req;
    while (pending != 0) begin
      n = 0;
      while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (busy !== 1'b1) begin
        check("grant_timeout", 32'(busy), 1);
        req = '0;
        return;
      end
      g  = cyc;
      id = pick(pending, exp_ptr);
      model(mx[id], my[id], md[id], blk, nx, ny, lat, lx, ly);
      n = 0;
      forever begin
        @(negedge clk);
        n++;
        if (done !== 4'b0 || n >= 20) break;
        req_x[id*10 +: 10] = 10'($urandom);
        req_y[id*9 +: 9]   = 9'($urandom);
        req_dir[id*2 +: 2] = 2'($urandom);
        if (disturb && n == 2) req[id] = 1'b0;
      end
      check("done_id", 32'(done), 32'(1 << id));
      check("latency", cyc - g, lat);
      check("blocked", 32'(blocked), blk);
      check("new_x", 32'(new_x), nx);
      check("new_y", 32'(new_y), ny);
      if (lat > 2) begin exp_px = lx; exp_py = ly; end
      check("probe_x_hold", 32'(probe_x), exp_px);
      check("probe_y_hold", 32'(probe_y), exp_py);
      exp_ptr = (id + 1) % 4;
      pending[id] = 1'b0;
      req[id] = 1'b0;
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0; exp_px = 0; exp_py = 0;
  endtask

  function automatic int rand_x();
    case ($urandom_range(0, 5))
      0: return $urandom_range(0, 2);
      1: return $urandom_range(630, 634);
      2: return 1023;
      default: return $urandom_range(0, 639);
    endcase
  endfunction

  function automatic int rand_y();
    case ($urandom_range(0, 5))
      0: return $urandom_range(0, 2);
      1: return $urandom_range(470, 474);
      2: return 511;
      default: return $urandom_range(0, 479);
    endcase
  endfunction

  initial begin
    int g, n, cnt, blk, nx, ny, lat, lx, ly;
    logic [3:0] mask;

    clear_map();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_blocked", 32'(blocked), 0);
    check("rst_new_x", 32'(new_x), 0);
    check("rst_new_y", 32'(new_y), 0);
    check("rst_probe_x", 32'(probe_x), 0);
    check("rst_probe_y", 32'(probe_y), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Open move, wall hit at the second corner, and a left-edge bounds refusal.
    set_mover(0, 16, 16, int'(DIR_RIGHT));
    serve(4'b0001, 1'b0);
    wall_map[2][0] = 1'b1;
    set_mover(0, 24, 0, int'(DIR_RIGHT));
    serve(4'b0001, 1'b0);
    set_mover(0, 0, 5, int'(DIR_LEFT));
    serve(4'b0001, 1'b0);

    // Request dropped and inputs scrambled after grant.
    clear_map();
    set_mover(1, 50, 60, int'(DIR_DOWN));
    serve(4'b0010, 1'b1);

    for (int b = 0; b < 40; b++) begin
      random_map();
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        if (mask[i]) set_mover(i, rand_x(), rand_y(), $urandom_range(0, 3));
      serve(mask, 1'($urandom_range(0, 1)));
    end

    // All four held: service order 0,1,2,3,0 from a fresh pointer.
    reset_dut();
    clear_map();
    for (int i = 0; i < 4; i++) set_mover(i, 16 + i * 40, 16, int'(DIR_RIGHT));
    req = 4'b1111;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 5; c++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        check("rr_order", 32'(done), 32'(1 << exp_ptr));
        model(mx[exp_ptr], my[exp_ptr], md[exp_ptr], blk, nx, ny, lat, lx, ly);
        check("rr_new_x", 32'(new_x), nx);
        exp_px = lx; exp_py = ly;
        exp_ptr = (exp_ptr + 1) % 4;
        cnt++;
      end
    end
    req = '0;
    check("rr_count", cnt, 5);
    @(negedge clk);
    check("rr_done_pulse", 32'(done), 0);

    // Reset during P2, then pending movers regranted from mover 0.
    set_mover(2, 100, 100, int'(DIR_DOWN));
    req = 4'b0100;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("p2_grant", 32'(busy), 1);
    g = cyc;
    repeat (3) @(negedge clk);
    check("p2_cycle", cyc - g, 3);
    check("p2_probe_x", 32'(probe_x), 100);
    check("p2_probe_y", 32'(probe_y), 108);
    set_mover(0, 200, 200, int'(DIR_UP));
    req[0] = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_blocked", 32'(blocked), 0);
    check("mid_rst_new_x", 32'(new_x), 0);
    check("mid_rst_new_y", 32'(new_y), 0);
    check("mid_rst_probe_x", 32'(probe_x), 0);
    check("mid_rst_probe_y", 32'(probe_y), 0);
    rst_n = 1'b1;
    exp_ptr = 0; exp_px = 0; exp_py = 0;
    set_mover(2, 100, 100, int'(DIR_DOWN));
    serve(4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
